// File: rtl/morse_uart_tx.sv
// Buffers letters captured from the Morse decoder's done edge and sends them
// out as 8N1 UART frames, LSB first; also holds the last accepted letter for the LEDs.
module morse_uart_tx #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    letter,
    input  logic                          done,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    last_letter
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [AW:0]     count_q, count_d;
    logic            done_q;
    logic            overflow_q, overflow_d;
    logic [7:0]      last_q, last_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    logic [7:0]      mem [FIFO_DEPTH];
    logic            capture, pop, push;

    // A full FIFO still accepts a letter when the head leaves on the same edge.
    assign capture = done & ~done_q;
    assign pop     = (state_q == IDLE) && (count_q != '0);
    assign push    = capture && ((count_q != COUNT_FULL) || pop);

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        last_d     = last_q;

        if (push) begin
            tail_d = tail_q + AW'(1);
            last_d = letter;
        end
        if (capture && !push) overflow_d = 1'b1;
        if (pop) head_d = head_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = mem[head_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so tx and busy line up with it.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            last_q     <= 8'h00;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            done_q     <= done;
            overflow_q <= overflow_d;
            last_q     <= last_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    // NOTE: the letter store has no reset; a zero count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[tail_q] <= letter;
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign last_letter = last_q;

endmodule

// File: tb/tb_morse_uart_tx.sv
// Self-checking bench for morse_uart_tx: a queue-based letter/frame model scored
// every cycle, a UART line receiver, and one task per scenario.
module tb_morse_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    letter = 8'h00;
    logic          done = 1'b0;
    logic          tx;
    logic          busy;
    logic [FW-1:0] fifo_count;
    logic          overflow;
    logic [7:0]    last_letter;

    int n_checks = 0;
    int n_fail = 0;
    int sb_prints = 0;
    int cyc = 0;

    morse_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .letter(letter), .done(done), .tx(tx),
        .busy(busy), .fifo_count(fifo_count), .overflow(overflow), .last_letter(last_letter)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural model: letters queue up, a frame occupies 10*CPB cycles after its pop.
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    int         m_bl = 0;
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_last = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_dprev = 1'b0;
    logic       m_pop, m_full, m_cap;

    always begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_q.delete();
            m_bl = 0; m_cur = 8'h00; m_last = 8'h00; m_ovf = 1'b0; m_dprev = 1'b0;
        end else begin
            m_pop  = (m_bl == 0) && (m_q.size() > 0);
            m_full = (m_q.size() == DEPTH);
            m_cap  = done && !m_dprev;
            m_dprev = done;
            if (m_bl > 0) m_bl--;
            if (m_pop) begin
                m_cur = m_q.pop_front();
                m_sent.push_back(m_cur);
                m_bl = 10 * CPB;
            end
            if (m_cap) begin
                if (!m_full || m_pop) begin
                    m_q.push_back(letter);
                    m_last = letter;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    function automatic logic exp_tx(input int bl, input logic [7:0] c);
        int idx;
        if (bl == 0) return 1'b1;
        idx = (10 * CPB - bl) / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return c[idx-1];
    endfunction

    // Per-cycle scoreboard of all outputs against the model.
    logic [19:0] sb_got, sb_exp;
    always begin
        @(negedge clk);
        sb_got = {tx, busy, 3'(fifo_count), overflow, last_letter, 6'd0};
        sb_exp = {exp_tx(m_bl, m_cur), (m_bl > 0), 3'(m_q.size()), m_ovf, m_last, 6'd0};
        n_checks++;
        if (sb_got !== sb_exp) begin
            n_fail++;
            if (sb_prints < 10)
                $display("FAIL scoreboard cyc=%0d {tx,busy,count,ovf,last}: got %h expected %h",
                         cyc, sb_got, sb_exp);
            sb_prints++;
        end
    end

    // UART receiver sampling mid-bit.
    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic       mon_on = 1'b0;
    logic       mon_prev = 1'b1;
    int         mon_cnt = 0;
    int         mon_start = 0;
    logic [7:0] mon_byte = 8'h00;

    always begin
        @(negedge clk);
        if (!reset_n) begin
            mon_on = 1'b0;
            mon_prev = 1'b1;
        end else begin
            if (mon_on) begin
                mon_cnt++;
                if ((mon_cnt % CPB == CPB / 2) && (mon_cnt / CPB >= 1) && (mon_cnt / CPB <= 8))
                    mon_byte[mon_cnt/CPB-1] = tx;
                if (mon_cnt == 9 * CPB + CPB / 2) begin
                    n_checks++;
                    if (tx !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stop_bit: got %b expected 1", tx);
                    end
                    rx_q.push_back(mon_byte);
                    rx_t.push_back(mon_start);
                    mon_on = 1'b0;
                end
            end else if (mon_prev === 1'b1 && tx === 1'b0) begin
                mon_on = 1'b1;
                mon_cnt = 0;
                mon_start = cyc;
            end
            mon_prev = tx;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        done = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse(input logic [7:0] l, input int hi);
        @(negedge clk);
        letter = l;
        done = 1'b1;
        repeat (hi) @(negedge clk);
        done = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (m_q.size() == 0 && m_bl == 0 && !mon_on) break;
        end
        if (i == 3000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got busy after %0d cycles expected idle", i);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (last_letter !== 8'h00) begin n_fail++; $display("FAIL reset_last: got %h expected 00", last_letter); end
    endtask

    task automatic test_single();
        logic [0:9] lv_seq;
        int nb;
        logic ok;
        lv_seq = 10'b0_11001010_1;
        clear_rx();
        @(negedge clk);
        letter = 8'h53;
        done = 1'b1;
        @(negedge clk);
        n_checks++; if (last_letter !== 8'h53) begin n_fail++; $display("FAIL single_last: got %h expected 53", last_letter); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count_capture: got %0d expected 1", fifo_count); end
        @(negedge clk);
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_count_pop: got %0d expected 0", fifo_count); end
        nb = 0;
        ok = 1'b1;
        if (busy === 1'b1) begin
            if (tx !== lv_seq[0]) ok = 1'b0;
            nb++;
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 0) done = 1'b0;
            if (busy === 1'b1) begin
                if (tx !== lv_seq[nb/CPB]) ok = 1'b0;
                nb++;
                if (nb >= 10 * CPB + 4) break;
            end else if (nb > 0) begin
                break;
            end
        end
        n_checks++; if (nb !== 10 * CPB) begin n_fail++; $display("FAIL single_busy_len: got %0d expected %0d", nb, 10 * CPB); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_tx_seq: got mismatch expected 0,1,1,0,0,1,0,1,0,1"); end
        drain();
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h53) begin
            n_fail++;
            $display("FAIL single_rx: got %0d frames expected one 53", rx_q.size());
        end
    endtask

    task automatic test_level_hold();
        int maxc;
        clear_rx();
        maxc = 0;
        @(negedge clk);
        letter = 8'h45;
        done = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        done = 1'b0;
        drain();
        n_checks++; if (maxc > 1) begin n_fail++; $display("FAIL hold_max_count: got %0d expected <=1", maxc); end
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h45) begin
            n_fail++;
            $display("FAIL hold_frames: got %0d frames expected one 45", rx_q.size());
        end
    endtask

    task automatic test_burst();
        logic ok;
        clear_rx();
        for (int i = 0; i < 6; i++) pulse(8'h41 + 8'(i), 1);
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL burst_count: got %0d expected 4", fifo_count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL burst_overflow: got %b expected 1", overflow); end
        n_checks++; if (last_letter !== 8'h45) begin n_fail++; $display("FAIL burst_last: got %h expected 45", last_letter); end
        drain();
        ok = (rx_q.size() == 5);
        for (int i = 0; i < 5 && ok; i++) if (rx_q[i] !== 8'h41 + 8'(i)) ok = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL burst_order: got %0d frames expected A..E", rx_q.size()); end
        ok = (rx_t.size() == 5);
        for (int i = 0; i < 4 && ok; i++) if (rx_t[i+1] - rx_t[i] != 10 * CPB + 1) ok = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL burst_spacing: got irregular expected %0d cycles", 10 * CPB + 1); end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] exp_l[6];
        logic ok;
        int i;
        exp_l = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h5A};
        do_reset();
        clear_rx();
        for (int k = 0; k < 5; k++) pulse(exp_l[k], 1);
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_bl == 0 && m_q.size() == DEPTH) break;
        end
        n_checks++; if (i == 200) begin n_fail++; $display("FAIL simul_setup: got timeout expected full and idle"); end
        letter = 8'h5A;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL simul_count: got %0d expected 4", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL simul_overflow: got %b expected 0", overflow); end
        n_checks++; if (last_letter !== 8'h5A) begin n_fail++; $display("FAIL simul_last: got %h expected 5a", last_letter); end
        drain();
        ok = (rx_q.size() == 6);
        for (int k = 0; k < 6 && ok; k++) if (rx_q[k] !== exp_l[k]) ok = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL simul_order: got %0d frames expected P,Q,R,S,T,Z", rx_q.size()); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_l[10];
        logic ok;
        clear_rx();
        for (int k = 0; k < 10; k++) begin
            exp_l[k] = 8'($urandom);
            pulse(exp_l[k], 2);
            repeat (45) @(negedge clk);
        end
        drain();
        ok = (rx_q.size() == 10);
        for (int k = 0; k < 10 && ok; k++) if (rx_q[k] !== exp_l[k]) ok = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_order: got %0d frames expected 10 in order", rx_q.size()); end
    endtask

    task automatic test_random();
        logic ok;
        clear_rx();
        @(negedge clk);
        m_sent.delete();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            done = ($urandom_range(0, 3) == 0);
            letter = 8'($urandom);
        end
        done = 1'b0;
        drain();
        ok = (rx_q.size() == m_sent.size()) && (rx_q.size() > 0);
        for (int k = 0; k < rx_q.size() && ok; k++) if (rx_q[k] !== m_sent[k]) ok = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL random_frames: got %0d frames expected %0d matching", rx_q.size(), m_sent.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int i;
        logic ok;
        clear_rx();
        pulse(8'h4D, 1);
        pulse(8'h4F, 1);
        pulse(8'h52, 1);
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_bl == 22) break;
        end
        n_checks++; if (i == 200) begin n_fail++; $display("FAIL midreset_setup: got timeout expected data bit 3"); end
        n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL midreset_pre_count: got %0d expected 2", fifo_count); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midreset_tx: got %b expected 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL midreset_count: got %0d expected 0", fifo_count); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset_idle: got tx low expected high after release"); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_level_hold();
        test_burst();
        test_simul_push_pop();
        test_wrap();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
